// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Signed operations run on magnitudes; the sign fix is applied in a single FIN cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_is_div;
  logic                 r_div0;
  logic                 r_neg_main;
  logic                 r_neg_rem;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_is_arith;
  logic                 w_op_signed;
  logic                 w_op_div;
  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic [WIDTH-1:0]     w_rs_mag;
  logic [WIDTH-1:0]     w_rt_mag;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [WIDTH-1:0]     w_rem_next;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Issue decode: ops 0-3 are multi-cycle, bit 0 selects unsigned, bit 1 selects divide.
  assign w_is_arith  = (op[2] == 1'b0);
  assign w_op_signed = ~op[0];
  assign w_op_div    = op[1];
  assign w_rs_neg    = w_op_signed & rs_val[WIDTH-1];
  assign w_rt_neg    = w_op_signed & rt_val[WIDTH-1];
  assign w_rs_mag    = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag    = w_rt_neg ? -rt_val : rt_val;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  assign w_prod_fix = r_neg_main ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_div0     <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && w_is_arith) begin
            r_acc      <= {{WIDTH{1'b0}}, (w_op_div ? w_rs_mag : w_rt_mag)};
            r_opnd     <= w_op_div ? w_rt_mag : w_rs_mag;
            r_is_div   <= w_op_div;
            r_div0     <= w_op_div & (rt_val == '0);
            r_neg_main <= w_rs_neg ^ w_rt_neg;
            r_neg_rem  <= w_rs_neg;
            r_cnt      <= '0;
            r_state    <= S_RUN;
          end else if (start && op == OP_MTHI) begin
            r_hi <= rs_val;
          end else if (start && op == OP_MTLO) begin
            r_lo <= rs_val;
          end
        end
        S_RUN: begin
          // Divide-by-zero keeps |rs| untouched in the low half so HI can return rs_val.
          if (!r_div0) begin
            if (r_is_div) r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_qbit};
            else          r_acc <= {w_add, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_FIN;
        end
        S_FIN: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else if (r_div0) begin
            r_lo <= '1;
            r_hi <= r_neg_rem ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          end else begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign stall  = busy | (start & w_is_arith & (r_state == S_IDLE));
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed boundary cases plus randomized
// MULT/DIV traffic compared against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  int n_checks = 0;
  int n_errors = 0;

  hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural result computed with ordinary 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint     sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); {eh, el} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; end
      3'd2: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); el = p[31:0];
          p = 64'(sr); eh = p[31:0];
        end
      end
      default: begin
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  // Issue one MULT/DIV-class op; optionally present another instruction mid-flight (inj_op >= 0).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inj_op);
    logic [31:0] eh, el, ph, pl;
    int          n;
    bit          held_ok, stall_ok;
    model(o, a, b, eh, el);
    @(negedge clk);
    ph = hi_out; pl = lo_out;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    #1 check({tag, "_issue_stall"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0; held_ok = 1'b1; stall_ok = 1'b1;
    while (!done && n < WIDTH + 8) begin
      if (inj_op >= 0 && n == 3) begin
        start = 1'b1; op = 3'(inj_op); rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!done) begin
        if (hi_out !== ph || lo_out !== pl) held_ok = 1'b0;
        if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(WIDTH + 1));
    check({tag, "_hold"}, 64'(held_ok), 64'd1);
    check({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
    check({tag, "_hi"}, 64'(hi_out), 64'(eh));
    check({tag, "_lo"}, 64'(lo_out), 64'(el));
    check({tag, "_done_stall"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ph, pl;
    bit          saw_done;
    reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
    #12;
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk); reset = 1'b1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max_hi_const", 64'(hi_out), 64'hFFFF_FFFE);
    run_op("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, -1);
    check("mult_m3x5_lo_const", 64'(lo_out), 64'hFFFF_FFF1);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2, -1);
    run_op("divu_by0", 3'd3, 32'h0000_1234, 32'd0, -1);
    run_op("div_by0_neg", 3'd2, 32'h8765_4321, 32'd0, -1);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, -1);
    run_op("mtlo_busy", 3'd1, 32'd1234, 32'd5678, 5);
    run_op("mthi_busy", 3'd0, 32'hDEAD_BEEF, 32'd3, 4);

    // MTHI/MTLO in IDLE update next edge without stalling.
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_val = 32'hA5A5_A5A5;
    #1 check("mthi_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi_out), 64'hA5A5_A5A5);
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    op = 3'd5; rs_val = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    check("mtlo_lo", 64'(lo_out), 64'h5A5A_0F0F);
    @(negedge clk);
    op = 3'd6; rs_val = 32'h1111_1111;
    #1 check("noop_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("noop_hi", 64'(hi_out), 64'hA5A5_A5A5);
    check("noop_lo", 64'(lo_out), 64'h5A5A_0F0F);

    // Reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_val = 32'd77; rt_val = 32'd99;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    @(negedge clk); reset = 1'b1;
    saw_done = 1'b0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_op("after_abort", 3'd0, 32'hFFFF_FFF9, 32'd6, -1);

    for (int i = 0; i < 36; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 3)), pick(), pick(),
             (i % 4 == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
